audio_sigma_delta_mixer: RTL and testbench
==========================================

// Module: audio_sigma_delta_mixer
// PURPOSE
//  Parametrised N-channel audio mixer with first-order delta-sigma 1-bit DACs for left/right pins.
//  Mixes the beeper/ear bit plus NCHAN unsigned PCM channels with per-channel L/R routing, mono mode and mute.
//  Sits between the machine core and audio_out_left/right; replaces driving both pins from one shared bit.
//  Includes an audio activity monostable for a front-panel LED.
// PARAMETERS
//  NCHAN  4      number of PCM channels (1..8)
//  DW     8      PCM sample width, unsigned
//  HOLD   2**21  activity hold time, clk cycles (>=2)
//  SW     derived localparam = DW + $clog2(NCHAN+1); mix-sum / accumulator width
// PORTS
//  clk         in   1          system clock (28 MHz domain)
//  rst_n       in   1          synchronous reset, active low
//  sample_stb  in   1          1-cycle strobe: latch ch_data, ch_pan
//  ch_data     in   NCHAN*DW   channel k at [k*DW +: DW]
//  ch_pan      in   2*NCHAN    channel k: bit 2k -> left, bit 2k+1 -> right
//  beeper      in   1          beeper/ear bit, asynchronous; enters both sides at full scale (2**DW-1)
//  mono        in   1          1: both pins driven from the left modulator
//  mute        in   1          1: mix sums forced to 0
//  audio_l     out  1          left delta-sigma bitstream
//  audio_r     out  1          right delta-sigma bitstream
//  activity    out  1          high while audio is active, plus HOLD cycles
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): latches, sums, accumulators, counter cleared.
//    audio_l=audio_r=activity=0. Synchronous reset also takes effect mid-stream.
//  - beeper: 2-FF synchroniser, every cycle. Synchroniser registers reset to 0.
//  - Stage 1, on sample_stb: ch_data and ch_pan latched. Held otherwise; the DAC keeps replaying them.
//  - Stage 2, every cycle, registered sums:
//    - sum_l = sum of DW-bit channels with pan L set, + (2**DW-1 if beeper_sync).
//    - sum_r is formed the same way from the pan R bits.
//    - mono=1: sum_l = sum over channels with either pan bit set, + beeper. sum_r unused.
//    - mute=1: sum_l = sum_r = 0.
//    - Width SW. No overflow possible; max (NCHAN+1)*(2**DW-1) < 2**SW.
//  - Stage 3, each side, every cycle: acc <= {1'b0, acc[SW-1:0]} + sum (SW+1 bits). audio_x <= carry bit acc[SW].
//    - Long-run density of 1s = sum/2**SW, error < 1 count per 2**SW cycles.
//    - mono=1: audio_r <= the same value as audio_l, identical every cycle.
//  - Latency:
//    - sample_stb edge -> stage-3 accumulators see the new sum 2 cycles later.
//    - beeper pin change -> 4 cycles.
//    - mute assertion -> audio_l/r low no later than cycle 3 after mute is seen.
//  - activity: set while any latched channel routed to an output is non-zero, or beeper_sync=1, and mute=0.
//    - While the condition holds: counter loads HOLD, activity=1.
//    - Otherwise: counter decrements to 0. activity=1 while counter != 0, then drops.
//  - Simultaneous sample_stb and mute: data is latched, output stays muted.
//  - Toggling mono mid-stream: accumulators are not cleared. A transient of at most 1 cycle is allowed.
// STRUCTURE
//  - Shared package audio_pkg:
//    - pan bit positions PAN_L=0, PAN_R=1
//    - function sum_width(nchan, dw)
//    - default DW/NCHAN constants
//  - Sub-module dsm1 (parameter W):
//    - one first-order modulator: clk, rst_n, in[W-1:0] -> out.
//    - instantiated twice, once per side.
//  - Mixer, synchroniser and activity counter live in the top of this block.
// TESTING  (NCHAN=4, DW=8 -> SW=11, window 2048 cycles)
//  1. Reset
//     - Hold rst_n=0 for 5 cycles with beeper=1 and all ch_data=FF.
//     - Then: audio_l=audio_r=activity=0 every cycle.
//     - Release, strobe with all pans 0 and beeper=0: outputs stay 0.
//  2. Single channel, left only
//     - ch0=0x80, pan=01, strobe; count over 2048 cycles after settle.
//     - audio_l ones = 128 +/-1; audio_r ones = 0.
//  3. Full scale, both sides
//     - All ch=0xFF, pans=11, beeper=1.
//     - Both sides: ones = 1275 +/-1 per 2048 cycles.
//  4. Mono mode
//     - mono=1, ch1=0x40 with pan=10 only.
//     - audio_l == audio_r on every cycle; ones = 64 +/-1.
//  5. Mute mid-stream
//     - Scenario 3 running, assert mute.
//     - audio_l=audio_r=0 by cycle 3 and for the rest of the mute.
//     - Deassert mute: density returns to 1275 +/-1.
//  6. Activity (HOLD=16)
//     - ch0=0x10, pan=01, strobe, then strobe ch0=0.
//     - activity stays 1 for 16 cycles after the zero reaches stage 2, then 0.
//     - rst_n=0 during the hold: activity=0 next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the sigma-delta audio mixer.
package audio_pkg;

   localparam int PAN_L     = 0;
   localparam int PAN_R     = 1;
   localparam int DEF_NCHAN = 4;
   localparam int DEF_DW    = 8;

   // Widest mix is (nchan+1) full-scale terms, so this many bits never overflow.
   function automatic int sum_width(input int nchan, input int dw);
      return dw + $clog2(nchan + 1);
   endfunction

endpackage

// File: rtl/audio_sigma_delta_mixer_dsm1.sv
// First-order delta-sigma modulator: the carry out of a W-bit accumulator is the bitstream.
module dsm1 #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in,
   output logic         out
);

   logic [W:0] r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else begin
         r_acc <= {1'b0, r_acc[W-1:0]} + {1'b0, in};
      end
   end

   assign out = r_acc[W];

endmodule

// File: rtl/audio_sigma_delta_mixer.sv
// N-channel PCM + beeper mixer driving left/right 1-bit delta-sigma DACs, with mono, mute
// and an activity monostable for the front-panel LED.
module audio_sigma_delta_mixer
   import audio_pkg::*;
#(
   parameter int NCHAN = DEF_NCHAN,
   parameter int DW    = DEF_DW,
   parameter int HOLD  = 2**21
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_stb,
   input  logic [NCHAN*DW-1:0] ch_data,
   input  logic [2*NCHAN-1:0]  ch_pan,
   input  logic                beeper,
   input  logic                mono,
   input  logic                mute,
   output logic                audio_l,
   output logic                audio_r,
   output logic                activity
);

   localparam int SW = sum_width(NCHAN, DW);
   localparam int CW = $clog2(HOLD + 1);
   localparam logic [SW-1:0] FULL_SCALE = SW'(2**DW - 1);

   logic                r_bp_meta;
   logic                r_bp_sync;
   logic [NCHAN*DW-1:0] r_data;
   logic [2*NCHAN-1:0]  r_pan;
   logic [SW-1:0]       r_sum_l;
   logic [SW-1:0]       r_sum_r;
   logic                r_mono;
   logic                r_act_cond;
   logic [CW-1:0]       r_cnt;

   logic [SW-1:0]       w_sum_l;
   logic [SW-1:0]       w_sum_r;
   logic                w_active;
   logic                w_out_l;
   logic                w_out_r;

   always_comb begin
      w_sum_l  = '0;
      w_sum_r  = '0;
      w_active = r_bp_sync;
      for (int k = 0; k < NCHAN; k++) begin
         if (mono) begin
            if (r_pan[2*k+PAN_L] || r_pan[2*k+PAN_R])
               w_sum_l = w_sum_l + SW'(r_data[k*DW +: DW]);
         end else begin
            if (r_pan[2*k+PAN_L]) w_sum_l = w_sum_l + SW'(r_data[k*DW +: DW]);
            if (r_pan[2*k+PAN_R]) w_sum_r = w_sum_r + SW'(r_data[k*DW +: DW]);
         end
         if ((r_pan[2*k+PAN_L] || r_pan[2*k+PAN_R]) && (r_data[k*DW +: DW] != '0))
            w_active = 1'b1;
      end
      if (r_bp_sync) begin
         w_sum_l = w_sum_l + FULL_SCALE;
         w_sum_r = w_sum_r + FULL_SCALE;
      end
      if (mute) begin
         w_sum_l  = '0;
         w_sum_r  = '0;
         w_active = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bp_meta  <= 1'b0;
         r_bp_sync  <= 1'b0;
         r_data     <= '0;
         r_pan      <= '0;
         r_sum_l    <= '0;
         r_sum_r    <= '0;
         r_mono     <= 1'b0;
         r_act_cond <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_bp_meta <= beeper;
         r_bp_sync <= r_bp_meta;
         if (sample_stb) begin
            r_data <= ch_data;
            r_pan  <= ch_pan;
         end
         r_sum_l    <= w_sum_l;
         r_sum_r    <= w_sum_r;
         r_mono     <= mono;
         r_act_cond <= w_active;
         // Retrigger while active; otherwise run the hold time down to zero.
         if (r_act_cond)
            r_cnt <= CW'(HOLD);
         else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   dsm1 #(.W(SW)) u_dsm_l (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (r_sum_l),
      .out   (w_out_l)
   );

   dsm1 #(.W(SW)) u_dsm_r (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (r_sum_r),
      .out   (w_out_r)
   );

   // Mono select is registered alongside the sums so both pins switch on the same edge.
   assign audio_l  = w_out_l;
   assign audio_r  = r_mono ? w_out_l : w_out_r;
   assign activity = (r_cnt != '0);

endmodule

// File: tb/tb_audio_sigma_delta_mixer.sv
// Self-checking bench for audio_sigma_delta_mixer: density vectors, random mixes vs a
// behavioural model, and hand-written mute/activity/reset sequences.
module tb_audio_sigma_delta_mixer;

   localparam int NCHAN = 4;
   localparam int DW    = 8;
   localparam int HOLD  = 16;
   localparam int WIN   = 2048;

   logic        clk;
   logic        rst_n;
   logic        sample_stb;
   logic [31:0] ch_data;
   logic [7:0]  ch_pan;
   logic        beeper;
   logic        mono;
   logic        mute;
   logic        audio_l;
   logic        audio_r;
   logic        activity;

   int n_tests = 0;
   int n_fail  = 0;

   audio_sigma_delta_mixer #(.NCHAN(NCHAN), .DW(DW), .HOLD(HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_stb (sample_stb),
      .ch_data    (ch_data),
      .ch_pan     (ch_pan),
      .beeper     (beeper),
      .mono       (mono),
      .mute       (mute),
      .audio_l    (audio_l),
      .audio_r    (audio_r),
      .activity   (activity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [7:0]  pan;
      logic        bp;
      logic        mo;
      logic        mu;
      int          exp_l;
      int          exp_r;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp, input int tol);
      n_tests++;
      if (act < exp - tol || act > exp + tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [31:0] d, input logic [7:0] p);
      ch_data    = d;
      ch_pan     = p;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
   endtask

   task automatic measure(output int n_l, output int n_r, output int n_mm);
      n_l  = 0;
      n_r  = 0;
      n_mm = 0;
      repeat (12) tick();
      for (int i = 0; i < WIN; i++) begin
         tick();
         n_l += int'(audio_l);
         n_r += int'(audio_r);
         if (audio_l !== audio_r) n_mm++;
      end
   endtask

   // Expected ones per 2048-cycle window = mix sum, from the routing rules directly.
   function automatic void model(input logic [31:0] d, input logic [7:0] p, input logic bp,
                                 input logic mo, input logic mu, output int el, output int er);
      el = 0;
      er = 0;
      if (!mu) begin
         for (int k = 0; k < NCHAN; k++) begin
            int v;
            v = int'(d[k*8 +: 8]);
            if (mo) begin
               if (p[2*k] || p[2*k+1]) el += v;
            end else begin
               if (p[2*k])   el += v;
               if (p[2*k+1]) er += v;
            end
         end
         if (bp) begin
            el += 255;
            er += 255;
         end
         if (mo) er = el;
      end
   endfunction

   task automatic run_vec(input string name, input logic [31:0] d, input logic [7:0] p,
                          input logic bp, input logic mo, input logic mu,
                          input int el, input int er);
      int n_l, n_r, n_mm;
      beeper = bp;
      mono   = mo;
      mute   = mu;
      strobe(d, p);
      measure(n_l, n_r, n_mm);
      check({name, "_l"}, n_l, el, 1);
      check({name, "_r"}, n_r, er, 1);
      if (mo) check({name, "_mono_eq"}, n_mm, 0, 0);
   endtask

   initial begin
      int n_l, n_r, n_mm, el, er, run, ones;
      logic [31:0] rd;
      logic [7:0]  rp;
      logic        rb, rmo, rmu;

      vecs[0] = '{"left_only",  32'h0000_0080, 8'h01, 1'b0, 1'b0, 1'b0,  128,    0};
      vecs[1] = '{"full_scale", 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1275, 1275};
      vecs[2] = '{"mono",       32'h0000_4000, 8'h08, 1'b0, 1'b1, 1'b0,   64,   64};
      vecs[3] = '{"muted_full", 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b0, 1'b1,    0,    0};
      vecs[4] = '{"right_mix",  32'h1130_0000, 8'hE0, 1'b0, 1'b0, 1'b0,   17,   65};
      vecs[5] = '{"beeper",     32'h0000_0000, 8'h00, 1'b1, 1'b0, 1'b0,  255,  255};
      vecs[6] = '{"no_route",   32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 1'b0,    0,    0};

      // Reset with everything driven high
      rst_n      = 1'b0;
      sample_stb = 1'b1;
      ch_data    = 32'hFFFF_FFFF;
      ch_pan     = 8'hFF;
      beeper     = 1'b1;
      mono       = 1'b0;
      mute       = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("reset_l", int'(audio_l), 0, 0);
         check("reset_r", int'(audio_r), 0, 0);
         check("reset_act", int'(activity), 0, 0);
      end
      sample_stb = 1'b0;
      beeper     = 1'b0;
      rst_n      = 1'b1;
      strobe(32'hFFFF_FFFF, 8'h00);
      ones = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         ones += int'(audio_l) + int'(audio_r) + int'(activity);
      end
      check("post_reset_quiet", ones, 0, 0);

      foreach (vecs[i])
         run_vec(vecs[i].name, vecs[i].data, vecs[i].pan, vecs[i].bp,
                 vecs[i].mo, vecs[i].mu, vecs[i].exp_l, vecs[i].exp_r);

      for (int i = 0; i < 6; i++) begin
         rd  = $urandom();
         rp  = 8'($urandom_range(0, 255));
         rb  = 1'($urandom_range(0, 1));
         rmo = 1'($urandom_range(0, 1));
         rmu = ($urandom_range(0, 4) == 0);
         model(rd, rp, rb, rmo, rmu, el, er);
         run_vec("random", rd, rp, rb, rmo, rmu, el, er);
      end

      // Mute mid-stream on full scale
      run_vec("pre_mute", 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1275, 1275);
      mute = 1'b1;
      repeat (3) tick();
      ones = 0;
      for (int i = 0; i < 300; i++) begin
         ones += int'(audio_l) + int'(audio_r);
         tick();
      end
      check("mute_silent", ones, 0, 0);
      mute = 1'b0;
      measure(n_l, n_r, n_mm);
      check("unmute_l", n_l, 1275, 1);
      check("unmute_r", n_r, 1275, 1);

      // Activity hold after the last non-zero sample
      beeper = 1'b0;
      strobe(32'h0000_0010, 8'h01);
      repeat (5) tick();
      check("act_on", int'(activity), 1, 0);
      strobe(32'h0000_0000, 8'h01);
      tick();
      run = 0;
      while (activity === 1'b1 && run < 100) begin
         run++;
         tick();
      end
      check("act_hold_len", run, HOLD, 0);
      repeat (3) tick();
      check("act_off", int'(activity), 0, 0);

      // Reset in the middle of a hold
      strobe(32'h0000_0010, 8'h01);
      repeat (4) tick();
      strobe(32'h0000_0000, 8'h01);
      repeat (5) tick();
      check("act_mid_hold", int'(activity), 1, 0);
      rst_n = 1'b0;
      tick();
      check("act_reset", int'(activity), 0, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
